// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs. MDU writeback, with starvation force and pending-write scoreboard.
// Optional sticky scoreboard error flag (sb_err) enabled by defining REGFILE_WB_ARB_ERRCHK_EN.
//
// state  | meaning
// IDLE   | no MDU result waiting beyond the current cycle
// WAIT   | MDU result held and denied; cnt counts denied cycles
// FORCE  | pipeline frozen this cycle; MDU owns the write port
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        pipe_stall,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
`ifdef REGFILE_WB_ARB_ERRCHK_EN
    output logic        sb_err,
`endif
    output logic        rf_we3
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pending_q, pending_d;

    logic wb_write;
    logic force_grant;
    logic mdu_hs;

    assign wb_write    = wb_we && (wb_addr != 5'd0);
    assign force_grant = (state_q == ST_FORCE);
    assign pipe_stall  = force_grant;
    assign mdu_hs      = mdu_valid && mdu_ready;

    // Write-port mux: WB has priority except in the forced cycle.
    always_comb begin
        mdu_ready = 1'b0;
        rf_we3    = 1'b0;
        rf_a3     = 5'd0;
        rf_wd3    = 32'd0;
        if (!RESET) begin
            if (!force_grant && wb_write) begin
                rf_we3 = 1'b1;
                rf_a3  = wb_addr;
                rf_wd3 = wb_data;
            end else if (mdu_valid) begin
                mdu_ready = 1'b1;
                if (mdu_addr != 5'd0) begin
                    rf_we3 = 1'b1;
                    rf_a3  = mdu_addr;
                    rf_wd3 = mdu_data;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu_valid && !mdu_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mdu_valid || mdu_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    state_d = ST_FORCE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FORCE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Set after clear so a same-cycle reissue to the retiring register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (mdu_hs) begin
            pending_d[mdu_addr] = 1'b0;
        end
        if (issue_valid && (issue_dst != 5'd0)) begin
            pending_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign rs_busy = (rs_addr != 5'd0) && pending_q[rs_addr];
    assign rt_busy = (rt_addr != 5'd0) && pending_q[rt_addr];

`ifdef REGFILE_WB_ARB_ERRCHK_EN
    logic       sb_err_q, sb_err_d;
    logic       held_q;
    logic [4:0] held_addr_q;

    always_comb begin
        sb_err_d = sb_err_q;
        if (issue_valid && (issue_dst != 5'd0) && pending_q[issue_dst]) begin
            sb_err_d = 1'b1;
        end
        if (mdu_hs && (mdu_addr != 5'd0) && !pending_q[mdu_addr]) begin
            sb_err_d = 1'b1;
        end
        if (held_q && mdu_valid && (mdu_addr != held_addr_q)) begin
            sb_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sb_err_q    <= 1'b0;
            held_q      <= 1'b0;
            held_addr_q <= 5'd0;
        end else begin
            sb_err_q    <= sb_err_d;
            held_q      <= mdu_valid && !mdu_ready;
            held_addr_q <= mdu_addr;
        end
    end

    assign sb_err = sb_err_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed sequences plus randomized traffic against a cycle model.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        pipe_stall;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we3;
`ifdef REGFILE_WB_ARB_ERRCHK_EN
    logic        sb_err;
`endif

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .pipe_stall(pipe_stall),
        .rf_a3(rf_a3), .rf_wd3(rf_wd3),
`ifdef REGFILE_WB_ARB_ERRCHK_EN
        .sb_err(sb_err),
`endif
        .rf_we3(rf_we3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int        cyc;
        bit        we;
        bit [4:0]  a;
        bit [31:0] d;
        bit        rdy;
        bit        stall;
        bit        rsb;
        bit        rtb;
        bit        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: denied-cycle count, pending set, sticky error.
    int   waited = 0;
    bit   pend[32];
    bit   m_err = 1'b0;
    bit   m_held = 1'b0;
    bit [4:0] m_held_addr = 5'd0;
    bit   m_rdy;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rf_we3", e.cyc, 32'(rf_we3), 32'(e.we));
            chk("rf_a3", e.cyc, 32'(rf_a3), 32'(e.a));
            chk("rf_wd3", e.cyc, rf_wd3, e.d);
            chk("mdu_ready", e.cyc, 32'(mdu_ready), 32'(e.rdy));
            chk("pipe_stall", e.cyc, 32'(pipe_stall), 32'(e.stall));
            chk("rs_busy", e.cyc, 32'(rs_busy), 32'(e.rsb));
            chk("rt_busy", e.cyc, 32'(rt_busy), 32'(e.rtb));
`ifdef REGFILE_WB_ARB_ERRCHK_EN
            chk("sb_err", e.cyc, 32'(sb_err), 32'(e.err));
`endif
        end
    end

    // One clock: predict outputs for current inputs, advance model at the edge, drop an accepted MDU result.
    task automatic step();
        exp_t e;
        bit   frc;
        bit   wbw;
        frc = (waited > MAX_WAIT);
        wbw = wb_we && (wb_addr != 5'd0);
        e.cyc = cyc; e.we = 0; e.a = 0; e.d = 0; e.rdy = 0;
        e.stall = frc;
        e.rsb = (rs_addr != 0) && pend[rs_addr];
        e.rtb = (rt_addr != 0) && pend[rt_addr];
        e.err = m_err;
        if (!RESET) begin
            if (!frc && wbw) begin
                e.we = 1; e.a = wb_addr; e.d = wb_data;
            end else if (mdu_valid) begin
                e.rdy = 1;
                if (mdu_addr != 0) begin
                    e.we = 1; e.a = mdu_addr; e.d = mdu_data;
                end
            end
        end
        exp_q.push_back(e);
        m_rdy = e.rdy;
        @(posedge CLK);
        if (RESET) begin
            waited = 0; m_err = 0; m_held = 0; m_held_addr = 0;
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            if (issue_valid && issue_dst != 0 && pend[issue_dst]) m_err = 1;
            if (mdu_valid && m_rdy && mdu_addr != 0 && !pend[mdu_addr]) m_err = 1;
            if (m_held && mdu_valid && mdu_addr != m_held_addr) m_err = 1;
            m_held = mdu_valid && !m_rdy;
            m_held_addr = mdu_addr;
            waited = (mdu_valid && !m_rdy) ? waited + 1 : 0;
            if (mdu_valid && m_rdy) pend[mdu_addr] = 0;
            if (issue_valid && issue_dst != 0) pend[issue_dst] = 1;
        end
        #1;
        cyc++;
        if (m_rdy) mdu_valid = 0;
    endtask

    task automatic idle_inputs();
        RESET = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        issue_valid = 0; issue_dst = 0; rs_addr = 0; rt_addr = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pend[i] = 0;
        idle_inputs();
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
        RESET = 1;
        @(posedge CLK); #1;
        step(); step();
        RESET = 0;
        step();

        // MDU alone is accepted in the same cycle
        mdu_valid = 1; mdu_addr = 5; mdu_data = 32'hDEADBEEF;
        step(); step();

        // WB priority, then MDU on the first free cycle
        wb_we = 1; wb_addr = 3; wb_data = 32'h11;
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h7777_0007;
        step(); step(); step();
        wb_we = 0;
        step(); step();

        // Starvation: WB held continuously, forced grant after MAX_WAIT+1 denied cycles
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        mdu_valid = 1; mdu_addr = 6; mdu_data = 32'h6666_0006;
        for (int i = 0; i < 14; i++) step();
        wb_we = 0;
        step();

        // Busy tracking up to and including the grant cycle
        issue_valid = 1; issue_dst = 9;
        step();
        issue_valid = 0; rs_addr = 9; rt_addr = 9;
        wb_we = 1; wb_addr = 2; wb_data = 32'h22;
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h9999;
        step(); step();
        wb_we = 0;
        step(); step(); step();

        // Reissue in the grant cycle keeps the register pending
        issue_valid = 1; issue_dst = 9;
        step();
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h9090;
        step();
        issue_valid = 0;
        step(); step();

        // Register 0 never busy; duplicate issue of reg 4
        rs_addr = 0; rt_addr = 4; issue_valid = 1; issue_dst = 0;
        step();
        issue_dst = 4;
        step(); step();
        issue_valid = 0;
        step(); step();

        // Reset mid-WAIT
        wb_we = 1; wb_addr = 3; wb_data = 32'h44;
        mdu_valid = 1; mdu_addr = 4; mdu_data = 32'h4444;
        rs_addr = 4;
        for (int i = 0; i < 4; i++) step();
        RESET = 1;
        step(); step();
        RESET = 0; wb_we = 0;
        step(); step(); step();

        // Randomized traffic with varying WB density
        for (int ph = 0; ph < 8; ph++) begin
            int dens;
            dens = $urandom_range(20, 97);
            for (int c = 0; c < 250; c++) begin
                RESET       = ($urandom % 300) == 0;
                wb_we       = ($urandom % 100) < dens;
                wb_addr     = 5'($urandom % 8);
                wb_data     = $urandom;
                if (!mdu_valid && ($urandom % 3) == 0) begin
                    mdu_valid = 1;
                    mdu_addr  = 5'($urandom % 8);
                    mdu_data  = $urandom;
                end
                issue_valid = ($urandom % 4) == 0;
                issue_dst   = 5'($urandom % 8);
                rs_addr     = 5'($urandom % 8);
                rt_addr     = 5'($urandom % 8);
                step();
            end
        end

        idle_inputs();
        mdu_valid = 0;
        step();
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port (A3/WD3/WE3), shared between the pipeline WB stage and the multi-cycle mult/div unit (MDU) writeback.
- WB has fixed priority. MDU uses a valid/ready handshake. A starvation FSM freezes the pipeline for one cycle if the MDU waits too long.
- Holds a 32-entry pending-write scoreboard of MDU destinations, which decode uses to stall reads/writes of in-flight registers.

Parameters:
- MAX_WAIT, 8: consecutive denied MDU cycles before a forced grant; legal range 1..255.
- CNT_W, 8: starvation counter width; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high
- wb_we  in  1  WB-stage write enable
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- mdu_valid  in  1  MDU result pending; held with addr/data until accepted
- mdu_addr  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  MDU result accepted this cycle
- issue_valid  in  1  decode issues an MDU op this cycle
- issue_dst  in  5  destination of the issued MDU op
- rs_addr  in  5  decode source A
- rt_addr  in  5  decode source B / destination
- rs_busy  out  1  rs_addr has a pending MDU write
- rt_busy  out  1  rt_addr has a pending MDU write
- pipe_stall  out  1  freeze all pipeline stages this cycle (registered)
- rf_a3  out  5  register-file write address
- rf_wd3  out  32  register-file write data
- rf_we3  out  1  register-file write enable

Behaviour:
- wb_write = wb_we && (wb_addr != 0).
- Write port outputs are combinational, zero latency; the register file commits on the same edge.
- Granting:
  - state != FORCE and wb_write: rf_* = wb_*, mdu_ready = 0.
  - Otherwise: mdu_ready = mdu_valid; when mdu_valid, rf_* = mdu_*.
  - When neither source writes: rf_we3 = 0, rf_a3 = 0, rf_wd3 = 0.
- An MDU write to register 0 completes the handshake, but rf_we3 = 0.
- While RESET = 1: rf_we3 = 0 and mdu_ready = 0, regardless of inputs.
- FSM states: IDLE, WAIT, FORCE. Reset to IDLE, cnt = 0.
  - IDLE: if mdu_valid && !mdu_ready, go to WAIT with cnt = 1; otherwise stay.
  - WAIT: on accept, go to IDLE with cnt = 0. If denied and cnt == MAX_WAIT, go to FORCE. Otherwise cnt += 1.
  - FORCE: pipe_stall = 1 for exactly this cycle. WB is ignored and the MDU is granted. Next state IDLE, cnt = 0.
  - WB's held write commits the following cycle, because the stalled WB stage keeps its contents.
- pipe_stall = (state == FORCE). Reset value 0.
- Scoreboard: pending[31:0], reset to 0; bit 0 is never set.
  - Set pending[issue_dst] on issue_valid when issue_dst != 0.
  - Clear pending[mdu_addr] on an MDU handshake (mdu_valid && mdu_ready).
  - Set and clear of the same index in the same cycle: set wins.
- rs_busy = pending[rs_addr] when rs_addr != 0, else 0. rt_busy is defined the same way.
  - Both are combinational from the registered scoreboard, so busy stays 1 during the grant cycle. The register file has no write-to-read bypass.
- Reset mid-operation clears the scoreboard, FSM and counter. The MDU must re-present its result after reset.

Optional Feature:
- Macro: REGFILE_WB_ARB_ERRCHK_EN.
- When defined:
  - Adds output sb_err (1 bit, sticky, reset 0).
  - sb_err sets on: issue_valid to a destination already pending; MDU handshake to a non-pending nonzero register; mdu_addr changing while mdu_valid is held and not accepted.
  - It clears only on RESET.
- When undefined: no sb_err port and no checking logic.

Test Plan:
- Reset, then mdu_valid = 1, mdu_addr = 5, mdu_data = 0xDEADBEEF, wb_we = 0 -> mdu_ready = 1 same cycle; rf_we3 = 1, rf_a3 = 5, rf_wd3 = 0xDEADBEEF.
- wb_we = 1, wb_addr = 3, wb_data = 0x11 together with an MDU request to reg 7 -> WB granted, mdu_ready = 0; MDU is granted the first cycle wb_we = 0.
- MAX_WAIT = 8, wb_write held continuously, MDU pending -> pipe_stall = 1 in exactly one cycle, 9 cycles after request; MDU written that cycle; WB write lands the next cycle.
- issue_valid with issue_dst = 9, then rs_addr = 9 -> rs_busy = 1 every cycle up to and including the grant cycle, 0 the cycle after.
- issue_valid with issue_dst = 9 in the same cycle as the MDU grant to reg 9 -> pending[9] stays 1.
- issue_dst = 0 and rs_addr = 0 -> rs_busy = 0; assert RESET mid-WAIT -> pending = 0, pipe_stall = 0, mdu_ready = 0 during reset.
- With REGFILE_WB_ARB_ERRCHK_EN: issue reg 4 twice -> sb_err = 1 the next cycle, held until RESET.
